// File: rtl/sum_arbiter_if.sv
// Bundle between the shared-adder arbiter, its requesters and the single sum instance.
// master = requesters plus adder side, slave = arbiter.
interface sum_arbiter_if #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] op_a_i;
    logic [N_REQ*WIDTH-1:0] op_b_i;
    logic [N_REQ*WIDTH-1:0] res_o;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic [IDX_W-1:0]       owner;
    logic [WIDTH-1:0]       sum_in_a;
    logic [WIDTH-1:0]       sum_in_b;
    logic [WIDTH-1:0]       sum_out;

    modport master (
        output req, op_a_i, op_b_i, sum_out,
        input  res_o, gnt, busy, owner, sum_in_a, sum_in_b
    );

    modport slave (
        input  req, op_a_i, op_b_i, sum_out,
        output res_o, gnt, busy, owner, sum_in_a, sum_in_b
    );
endinterface

// File: rtl/sum_arbiter.sv
// Round-robin, session-locked arbiter sharing one combinational adder among N_REQ units.
// Optional macro SUM_ARB_FAST_HANDOFF_EN: hand the grant straight to the next winner on release.
module sum_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned WIDTH = 16
) (
    input logic          clk,
    input logic          rst,
    sum_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE, OWNED} state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             busy_q, busy_d;

    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_hit;
    logic [N_REQ-1:0] rr_onehot;

    // First pending request scanning owner+1, owner+2, ... with wrap
    always_comb begin
        cand      = owner_q;
        rr_idx    = owner_q;
        rr_hit    = 1'b0;
        rr_onehot = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((32'(owner_q) + i) % N_REQ);
            if (!rr_hit && bus.req[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
        if (rr_hit) rr_onehot[rr_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (rr_hit) begin
                    gnt_d   = rr_onehot;
                    owner_d = rr_idx;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                // owner keeps its value on release so it serves as the rotation pointer
                if (!bus.req[owner_q]) begin
`ifdef SUM_ARB_FAST_HANDOFF_EN
                    if (rr_hit) begin
                        gnt_d   = rr_onehot;
                        owner_d = rr_idx;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
`else
                    gnt_d   = '0;
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = |gnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= IDX_W'(N_REQ - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    // Operand mux and result steering follow the registered grant
    always_comb begin
        bus.sum_in_a = '0;
        bus.sum_in_b = '0;
        bus.res_o    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt_q[k]) begin
                bus.sum_in_a               = bus.op_a_i[k*WIDTH +: WIDTH];
                bus.sum_in_b               = bus.op_b_i[k*WIDTH +: WIDTH];
                bus.res_o[k*WIDTH +: WIDTH] = bus.sum_out;
            end
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;
endmodule

// File: tb/tb_sum_arbiter.sv
// Self-checking bench for sum_arbiter: directed vector table, hand sequences and
// randomized traffic compared against a pointer/grant-index reference model.
module tb_sum_arbiter;
    localparam int unsigned N = 2;
    localparam int unsigned W = 16;
`ifdef SUM_ARB_FAST_HANDOFF_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        logic [N-1:0]   gnt;
        int             owner;
        logic [N*W-1:0] res;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sum_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
    sum_arbiter #(.N_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.sum_out = bus.sum_in_a + bus.sum_in_b;

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [N-1:0]   cur_r;
    logic [N*W-1:0] cur_a, cur_b;
    int             m_gnt;
    int             m_owner;
    vec_t           tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r);
        for (int i = 1; i <= int'(N); i++) begin
            int c;
            c = (m_owner + i) % int'(N);
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_gnt   = -1;
        m_owner = int'(N) - 1;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        if (m_gnt >= 0 && r[m_gnt]) return;
        if (m_gnt >= 0 && !FAST) begin
            m_gnt = -1;
            return;
        end
        m_gnt = rr_pick(r);
        if (m_gnt >= 0) m_owner = m_gnt;
    endtask

    task automatic check_model();
        logic [N-1:0]   eg;
        logic [W-1:0]   ea, eb;
        logic [N*W-1:0] er;
        eg = '0; ea = '0; eb = '0; er = '0;
        if (m_gnt >= 0) begin
            eg[m_gnt] = 1'b1;
            ea = cur_a[m_gnt*W +: W];
            eb = cur_b[m_gnt*W +: W];
            er[m_gnt*W +: W] = W'(ea + eb);
        end
        chk("mdl_gnt", 64'(bus.gnt), 64'(eg));
        chk("mdl_busy", 64'(bus.busy), 64'(m_gnt >= 0));
        chk("mdl_owner", 64'(bus.owner), 64'(m_owner));
        chk("mdl_sum_in_a", 64'(bus.sum_in_a), 64'(ea));
        chk("mdl_sum_in_b", 64'(bus.sum_in_b), 64'(eb));
        chk("mdl_res_o", 64'(bus.res_o), 64'(er));
    endtask

    // Called in the low clock phase; returns at the following negedge
    task automatic apply(input logic [N-1:0] r, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        bus.req = r; bus.op_a_i = a; bus.op_b_i = b;
        cur_r = r; cur_a = a; cur_b = b;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        cur_r = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic vec_t mk(input logic [N-1:0] r, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                input logic [N-1:0] g, input int o, input logic [N*W-1:0] res);
        vec_t v;
        v.req = r; v.a = a; v.b = b; v.gnt = g; v.owner = o; v.res = res;
        return v;
    endfunction

    initial begin
        logic [N*W-1:0] sa, sb;
        bus.req = '0; bus.op_a_i = '0; bus.op_b_i = '0;
        cur_r = '0; cur_a = '0; cur_b = '0;
        model_reset();

        sa = 32'h000A_0005; sb = 32'h0014_0006;
        for (int i = 0; i < 5; i++) tbl.push_back(mk(2'b11, sa, sb, 2'b01, 0, 32'h0000_000B));
        tbl.push_back(mk(2'b10, sa, sb, FAST ? 2'b10 : 2'b00, FAST ? 1 : 0, FAST ? 32'h001E_0000 : 32'h0));
        tbl.push_back(mk(2'b10, sa, sb, 2'b10, 1, 32'h001E_0000));
        tbl.push_back(mk(2'b11, sa, sb, 2'b10, 1, 32'h001E_0000));
        tbl.push_back(mk(2'b01, sa, sb, FAST ? 2'b01 : 2'b00, FAST ? 0 : 1, FAST ? 32'h0000_000B : 32'h0));
        tbl.push_back(mk(2'b01, sa, sb, 2'b01, 0, 32'h0000_000B));
        tbl.push_back(mk(2'b01, 32'h0000_FFFF, 32'h0000_0002, 2'b01, 0, 32'h0000_0001));
        tbl.push_back(mk(2'b00, 32'h0000_FFFF, 32'h0000_0002, 2'b00, 0, 32'h0));
        tbl.push_back(mk(2'b10, 32'h0003_1234, 32'h0004_0001, 2'b10, 1, 32'h0007_0000));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk((i % 2 == 0) ? 2'b11 : 2'b10, 32'h0003_1234, 32'h0004_0001, 2'b10, 1, 32'h0007_0000));

        // Reset state
        do_reset();
        chk("rst_gnt", 64'(bus.gnt), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_owner", 64'(bus.owner), 64'(N - 1));
        chk("rst_sum_in_a", 64'(bus.sum_in_a), 64'h0);

        // Single request from reset
        apply(2'b01, 32'h0000_001B, 32'h0000_0064);
        chk("single_gnt", 64'(bus.gnt), 64'h1);
        chk("single_sum_in_a", 64'(bus.sum_in_a), 64'd27);
        chk("single_sum_in_b", 64'(bus.sum_in_b), 64'd100);
        chk("single_res_o", 64'(bus.res_o), 64'h0000_007F);
        apply(2'b00, 32'h0000_001B, 32'h0000_0064);
        chk("release_gnt", 64'(bus.gnt), 64'h0);
        chk("release_sum_in", 64'({bus.sum_in_a, bus.sum_in_b}), 64'h0);

        // Vector table: simultaneous requests, bubble/handoff, wrap arithmetic, lock
        do_reset();
        foreach (tbl[i]) begin
            apply(tbl[i].req, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d_gnt", i), 64'(bus.gnt), 64'(tbl[i].gnt));
            chk($sformatf("tbl%0d_owner", i), 64'(bus.owner), 64'(tbl[i].owner));
            chk($sformatf("tbl%0d_res", i), 64'(bus.res_o), 64'(tbl[i].res));
        end

        // Asynchronous reset in the middle of a session
        do_reset();
        apply(2'b10, 32'h0001_0000, 32'h0002_0000);
        chk("async_pre_gnt", 64'(bus.gnt), 64'h2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_gnt", 64'(bus.gnt), 64'h0);
        chk("async_busy", 64'(bus.busy), 64'h0);
        chk("async_owner", 64'(bus.owner), 64'(N - 1));
        bus.req = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        apply(2'b11, 32'h0001_0000, 32'h0002_0000);
        chk("async_post_gnt", 64'(bus.gnt), 64'h1);

        // Owner release with another request pending
        do_reset();
        apply(2'b11, 32'h0005_0007, 32'h0006_0008);
        chk("handoff_pre_gnt", 64'(bus.gnt), 64'h1);
        apply(2'b10, 32'h0005_0007, 32'h0006_0008);
        chk("handoff_gnt", 64'(bus.gnt), FAST ? 64'h2 : 64'h0);
        chk("handoff_busy", 64'(bus.busy), FAST ? 64'h1 : 64'h0);
        apply(2'b10, 32'h0005_0007, 32'h0006_0008);
        chk("handoff_post_gnt", 64'(bus.gnt), 64'h2);
        chk("handoff_post_res", 64'(bus.res_o), 64'h000B_0000);

        // Randomized traffic with sticky requests
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] r;
            r = cur_r;
            for (int k = 0; k < int'(N); k++)
                if ($urandom_range(3) == 0) r[k] = ~r[k];
            apply(r, (N*W)'({$urandom, $urandom}), (N*W)'({$urandom, $urandom}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sum_arbiter.md
Name: sum_arbiter

Overview:
- Shares one external combinational `sum` adder (16-bit a+b) between N_REQ multi-cycle arithmetic units, e.g. two iterative root units.
- Round-robin arbitration with a registered grant. The grant is locked for as long as the owner holds its request.
- Operands of the granted requester are muxed to the adder; the adder result is routed back only to the granted requester.
- Sits between the compute units and the single `sum` instance at the top level.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- WIDTH, 16, operand/result width; must match the `sum` instance.
- IDX_W, $clog2(N_REQ) (min 1), width of owner index; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request; held high for the whole adder-use session.
- op_a_i  input  N_REQ*WIDTH  packed operand A; slice k belongs to requester k.
- op_b_i  input  N_REQ*WIDTH  packed operand B; slice k belongs to requester k.
- res_o  output  N_REQ*WIDTH  packed results; slice k = sum_out when gnt[k], else 0.
- gnt  output  N_REQ  registered one-hot grant; all zero when idle.
- busy  output  1  high while any grant is active (equals |gnt).
- owner  output  IDX_W  index of current/last owner.
- sum_in_a  output  WIDTH  to adder input a.
- sum_in_b  output  WIDTH  to adder input b.
- sum_out  input  WIDTH  from adder result.

Behaviour:
- Reset values: gnt=0, busy=0, owner=N_REQ-1, state=IDLE.
  - owner=N_REQ-1 means requester 0 has first priority after reset.
  - Reset acts immediately and asynchronously, including mid-session: gnt drops without waiting for an edge and the pointer is restored.
- State machine: two states, IDLE and OWNED.
  - IDLE: at a posedge with req!=0, pick the first set req bit scanning owner+1, owner+2, … with wrap modulo N_REQ. Set gnt to that one-hot, set owner to its index, go to OWNED. With req==0, stay in IDLE.
  - OWNED: at a posedge with req[owner]=1, hold gnt unchanged. Other requests are ignored (lock); no preemption.
  - OWNED, owner drops its request: at a posedge with req[owner]=0, gnt<=0 and go to IDLE. owner keeps its value so it acts as the round-robin pointer. This costs one bubble cycle before the next grant.
- Latency: req rise to gnt high = 1 clk when the arbiter is idle. Requesters must not use res_o before they see gnt.
- Datapath (combinational from registered gnt):
  - sum_in_a/sum_in_b = operands of the granted slice; both are 0 when gnt==0.
  - res_o slice k = sum_out when gnt[k], else 0.
  - No width growth: carry is discarded, as in `sum`.
- Simultaneous requests: resolved purely by the rotating pointer. A requester whose req falls before it is granted is never granted.
- Requester with index >= N_REQ: does not exist; no out-of-range grant is possible.
- Invariant: gnt is always one-hot or zero.

Optional Feature:
- Macro: SUM_ARB_FAST_HANDOFF_EN.
- Defined: in OWNED, when req[owner]=0 and another req bit is set at the same posedge, the grant moves directly to the next round-robin winner (scan from old owner+1). owner updates to the new index, state stays OWNED, busy stays high, and there is no bubble. If no other request is pending, behaviour is the same as without the macro.
- Undefined: the mandatory one-cycle idle bubble described in Behaviour applies.

Test Plan (N_REQ=2, WIDTH=16):
- Reset then single request: req=01, op_a0=27, op_b0=100 → gnt=01 one clk later; sum_in_a=27, sum_in_b=100; res_o[15:0]=127, res_o[31:16]=0. req drops → gnt=00 next clk; sum_in_a=sum_in_b=0.
- Simultaneous request after reset: req=11 → gnt=01. Requester 0 holds for 5 clks, then releases → gnt=00 for 1 clk, then gnt=10 (owner=1). Requester 1 releases while requester 0 still requests → requester 0 granted again.
- Lock: requester 1 owns the adder; requester 0 toggles req every clk for 10 clks → gnt stays 10 throughout; res_o[15:0]=0 throughout.
- Wrap-around arithmetic: granted requester drives op_a=16'hFFFF, op_b=16'h0002 → its res_o slice=16'h0001.
- Async reset mid-session: gnt=10, assert rst between clock edges → gnt=00 and busy=0 before the next posedge. Release rst with req=11 → gnt=01.
- SUM_ARB_FAST_HANDOFF_EN build: req=11, requester 0 owner drops req → gnt goes 01→10 in one clk with busy continuously high. Same stimulus without the macro shows a single gnt=00 cycle.
